// File: rtl/gprs_wr_sched_if.sv
// Port bundle for the GPR write-port scheduler: WB, issue, MDU/LSU returns,
// debug register access and the register-file side.
interface gprs_wr_sched_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5
);
  logic                       wb_valid;
  logic [RD_WIDTH-1:0]        wb_rd;
  logic [DATA_WIDTH-1:0]      wb_data;
  logic                       iss_valid;
  logic [RD_WIDTH-1:0]        iss_rd;
  logic                       mdu_valid;
  logic [RD_WIDTH-1:0]        mdu_rd;
  logic [DATA_WIDTH-1:0]      mdu_data;
  logic                       mdu_ready;
  logic                       lsu_valid;
  logic [RD_WIDTH-1:0]        lsu_rd;
  logic [DATA_WIDTH-1:0]      lsu_data;
  logic                       lsu_ready;
  logic                       dbg_req;
  logic                       dbg_wr1_rd0;
  logic [RD_WIDTH-1:0]        dbg_regno;
  logic [DATA_WIDTH-1:0]      dbg_wdata;
  logic                       dbg_ack;
  logic [DATA_WIDTH-1:0]      dbg_rdata;
  logic [RD_WIDTH-1:0]        rf_dbg_ridx;
  logic [DATA_WIDTH-1:0]      rf_dbg_rdata;
  logic                       rf_wr_valid;
  logic [RD_WIDTH-1:0]        rf_wr_rd;
  logic [DATA_WIDTH-1:0]      rf_wr_data;
  logic [(1<<RD_WIDTH)-1:0]   busy;

  modport master (
    output wb_valid, wb_rd, wb_data, iss_valid, iss_rd,
    output mdu_valid, mdu_rd, mdu_data, lsu_valid, lsu_rd, lsu_data,
    output dbg_req, dbg_wr1_rd0, dbg_regno, dbg_wdata, rf_dbg_rdata,
    input  mdu_ready, lsu_ready, dbg_ack, dbg_rdata, rf_dbg_ridx,
    input  rf_wr_valid, rf_wr_rd, rf_wr_data, busy
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, iss_valid, iss_rd,
    input  mdu_valid, mdu_rd, mdu_data, lsu_valid, lsu_rd, lsu_data,
    input  dbg_req, dbg_wr1_rd0, dbg_regno, dbg_wdata, rf_dbg_rdata,
    output mdu_ready, lsu_ready, dbg_ack, dbg_rdata, rf_dbg_ridx,
    output rf_wr_valid, rf_wr_rd, rf_wr_data, busy
  );
endinterface

// File: rtl/gprs_wr_sched.sv
// Single GPR write-port scheduler: WB > MDU/LSU holds (round-robin) > debug write,
// with a pending-write scoreboard and a debug register-access FSM.
module gprs_wr_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5
) (
  input logic            clk,
  input logic            rstn,
  gprs_wr_sched_if.slave bus
);
  localparam int unsigned NumRegs = 1 << RD_WIDTH;

  typedef enum logic [1:0] {StIdle, StWrWait, StRdWait, StAck} dbg_state_e;

  dbg_state_e            state_q, state_d;
  logic                  mdu_hv_q, mdu_hv_d, lsu_hv_q, lsu_hv_d;
  logic [RD_WIDTH-1:0]   mdu_hrd_q, mdu_hrd_d, lsu_hrd_q, lsu_hrd_d;
  logic [DATA_WIDTH-1:0] mdu_hdata_q, mdu_hdata_d, lsu_hdata_q, lsu_hdata_d;
  logic                  rr_q, rr_d;  // 0: MDU wins a tie
  logic [NumRegs-1:0]    busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic wb_write, mdu_gnt, lsu_gnt, dbg_wr_gnt, rd_clear;

  always_comb begin
    wb_write = bus.wb_valid && (bus.wb_rd != '0);
    mdu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;
    // Any wb_valid, even to x0, blocks the holds and debug.
    if (!bus.wb_valid) begin
      if (mdu_hv_q && lsu_hv_q) begin
        mdu_gnt = !rr_q;
        lsu_gnt = rr_q;
      end else begin
        mdu_gnt = mdu_hv_q;
        lsu_gnt = lsu_hv_q;
      end
    end
    dbg_wr_gnt = (state_q == StWrWait) && (bus.dbg_regno != '0) && !bus.wb_valid &&
                 !mdu_hv_q && !lsu_hv_q;
  end

  assign bus.mdu_ready = !mdu_hv_q || mdu_gnt;
  assign bus.lsu_ready = !lsu_hv_q || lsu_gnt;

  always_comb begin
    bus.rf_wr_valid = 1'b0;
    bus.rf_wr_rd    = '0;
    bus.rf_wr_data  = '0;
    if (wb_write) begin
      bus.rf_wr_valid = 1'b1;
      bus.rf_wr_rd    = bus.wb_rd;
      bus.rf_wr_data  = bus.wb_data;
    end else if (mdu_gnt) begin
      bus.rf_wr_valid = 1'b1;
      bus.rf_wr_rd    = mdu_hrd_q;
      bus.rf_wr_data  = mdu_hdata_q;
    end else if (lsu_gnt) begin
      bus.rf_wr_valid = 1'b1;
      bus.rf_wr_rd    = lsu_hrd_q;
      bus.rf_wr_data  = lsu_hdata_q;
    end else if (dbg_wr_gnt) begin
      bus.rf_wr_valid = 1'b1;
      bus.rf_wr_rd    = bus.dbg_regno;
      bus.rf_wr_data  = bus.dbg_wdata;
    end
  end

  // Holds, round-robin pointer and scoreboard next state.
  always_comb begin
    mdu_hv_d    = mdu_hv_q && !mdu_gnt;
    mdu_hrd_d   = mdu_hrd_q;
    mdu_hdata_d = mdu_hdata_q;
    lsu_hv_d    = lsu_hv_q && !lsu_gnt;
    lsu_hrd_d   = lsu_hrd_q;
    lsu_hdata_d = lsu_hdata_q;
    if (bus.mdu_valid && bus.mdu_ready) begin
      mdu_hv_d    = (bus.mdu_rd != '0);
      mdu_hrd_d   = bus.mdu_rd;
      mdu_hdata_d = bus.mdu_data;
    end
    if (bus.lsu_valid && bus.lsu_ready) begin
      lsu_hv_d    = (bus.lsu_rd != '0);
      lsu_hrd_d   = bus.lsu_rd;
      lsu_hdata_d = bus.lsu_data;
    end
    rr_d   = rr_q ^ (mdu_gnt || lsu_gnt);
    busy_d = busy_q;
    if (mdu_gnt) busy_d[mdu_hrd_q] = 1'b0;
    if (lsu_gnt) busy_d[lsu_hrd_q] = 1'b0;
    if (bus.iss_valid) busy_d[bus.iss_rd] = 1'b1;  // set after clear: set wins
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d         = state_q;
    rdata_d         = rdata_q;
    bus.dbg_ack     = 1'b0;
    bus.rf_dbg_ridx = '0;
    rd_clear = !busy_q[bus.dbg_regno] &&
               !(mdu_hv_q && (mdu_hrd_q == bus.dbg_regno)) &&
               !(lsu_hv_q && (lsu_hrd_q == bus.dbg_regno)) &&
               !(wb_write && (bus.wb_rd == bus.dbg_regno));
    unique case (state_q)
      StIdle: begin
        if (bus.dbg_req) state_d = bus.dbg_wr1_rd0 ? StWrWait : StRdWait;
      end
      StWrWait: begin
        if (bus.dbg_regno == '0 || dbg_wr_gnt) state_d = StAck;
      end
      StRdWait: begin
        bus.rf_dbg_ridx = bus.dbg_regno;
        if (rd_clear) begin
          rdata_d = bus.rf_dbg_rdata;
          state_d = StAck;
        end
      end
      StAck: begin
        bus.dbg_ack = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.dbg_rdata = rdata_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      mdu_hv_q    <= 1'b0;
      mdu_hrd_q   <= '0;
      mdu_hdata_q <= '0;
      lsu_hv_q    <= 1'b0;
      lsu_hrd_q   <= '0;
      lsu_hdata_q <= '0;
      rr_q        <= 1'b0;
      busy_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mdu_hv_q    <= mdu_hv_d;
      mdu_hrd_q   <= mdu_hrd_d;
      mdu_hdata_q <= mdu_hdata_d;
      lsu_hv_q    <= lsu_hv_d;
      lsu_hrd_q   <= lsu_hrd_d;
      lsu_hdata_q <= lsu_hdata_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_gprs_wr_sched.sv
// Directed bench for gprs_wr_sched; a small register-file model feeds debug reads.
module tb_gprs_wr_sched;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;
  logic [31:0] rf [32];

  gprs_wr_sched_if #(.DATA_WIDTH(32), .RD_WIDTH(5)) bus ();

  gprs_wr_sched #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rf_wr_valid) rf[bus.rf_wr_rd] <= bus.rf_wr_data;
  end
  assign bus.rf_dbg_rdata = rf[bus.rf_dbg_ridx];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr();
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.dbg_req = 0; bus.dbg_wr1_rd0 = 0; bus.dbg_regno = 0; bus.dbg_wdata = 0;
  endtask

  // Drive window starts 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0;
    clr();
    #1;
    check("rst_mdu_ready", bus.mdu_ready, 1);
    check("rst_lsu_ready", bus.lsu_ready, 1);
    check("rst_dbg_ack", bus.dbg_ack, 0);
    check("rst_dbg_rdata", bus.dbg_rdata, 0);
    check("rst_ridx", bus.rf_dbg_ridx, 0);
    check("rst_wr_valid", bus.rf_wr_valid, 0);
    check("rst_busy", bus.busy, 0);
    tick();
    rstn = 1'b1;

    // WB path, zero latency
    tick();
    bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h1234;
    #1;
    check("wb_valid", bus.rf_wr_valid, 1);
    check("wb_rd", bus.rf_wr_rd, 3);
    check("wb_data", bus.rf_wr_data, 32'h1234);
    bus.wb_rd = 0;
    #1;
    check("wb_x0_valid", bus.rf_wr_valid, 0);
    check("wb_x0_data", bus.rf_wr_data, 0);
    tick();
    clr();

    // Scoreboard: MDU result blocked by 3 cycles of WB
    bus.iss_valid = 1; bus.iss_rd = 7;
    tick();
    clr();
    #1;
    check("sb_busy7_set", bus.busy[7], 1);
    bus.wb_valid = 1; bus.wb_rd = 10; bus.wb_data = 1;
    bus.mdu_valid = 1; bus.mdu_rd = 7; bus.mdu_data = 32'hA5A5;
    #1;
    check("sb_mdu_ready_empty", bus.mdu_ready, 1);
    tick();
    bus.mdu_valid = 0;
    #1;
    check("sb_mdu_ready_blk1", bus.mdu_ready, 0);
    check("sb_wb_wins", bus.rf_wr_rd, 10);
    check("sb_busy7_blk1", bus.busy[7], 1);
    tick();
    #1;
    check("sb_mdu_ready_blk2", bus.mdu_ready, 0);
    check("sb_busy7_blk2", bus.busy[7], 1);
    tick();
    bus.wb_valid = 0;
    #1;
    check("sb_mdu_wr_valid", bus.rf_wr_valid, 1);
    check("sb_mdu_wr_rd", bus.rf_wr_rd, 7);
    check("sb_mdu_wr_data", bus.rf_wr_data, 32'hA5A5);
    check("sb_busy7_at_grant", bus.busy[7], 1);
    check("sb_mdu_ready_gnt", bus.mdu_ready, 1);
    tick();
    #1;
    check("sb_busy7_clr", bus.busy[7], 0);
    check("sb_idle", bus.rf_wr_valid, 0);

    // Round-robin from a freshly reset pointer
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    tick();
    bus.mdu_valid = 1; bus.mdu_rd = 1; bus.mdu_data = 32'h11;
    bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h22;
    tick();
    clr();
    #1;
    check("rr1_first_rd", bus.rf_wr_rd, 1);
    check("rr1_first_data", bus.rf_wr_data, 32'h11);
    check("rr1_lsu_ready_blk", bus.lsu_ready, 0);
    tick();
    #1;
    check("rr1_second_rd", bus.rf_wr_rd, 2);
    check("rr1_second_data", bus.rf_wr_data, 32'h22);
    tick();
    bus.mdu_valid = 1; bus.mdu_rd = 3; bus.mdu_data = 32'h33;
    tick();
    clr();
    #1;
    check("rr_single_rd", bus.rf_wr_rd, 3);
    tick();
    bus.mdu_valid = 1; bus.mdu_rd = 1; bus.mdu_data = 32'h11;
    bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h22;
    tick();
    clr();
    #1;
    check("rr2_first_rd", bus.rf_wr_rd, 2);
    tick();
    #1;
    check("rr2_second_rd", bus.rf_wr_rd, 1);
    tick();
    #1;
    check("rr2_idle", bus.rf_wr_valid, 0);

    // Debug write behind a pending LSU hold
    bus.lsu_valid = 1; bus.lsu_rd = 6; bus.lsu_data = 32'h66;
    tick();
    clr();
    bus.dbg_req = 1; bus.dbg_wr1_rd0 = 1; bus.dbg_regno = 9; bus.dbg_wdata = 32'hDEADBEEF;
    #1;
    check("dw_lsu_first", bus.rf_wr_rd, 6);
    check("dw_ack_early", bus.dbg_ack, 0);
    tick();
    #1;
    check("dw_wr_rd", bus.rf_wr_rd, 9);
    check("dw_wr_data", bus.rf_wr_data, 32'hDEADBEEF);
    check("dw_ack_at_write", bus.dbg_ack, 0);
    tick();
    #1;
    check("dw_ack", bus.dbg_ack, 1);
    check("dw_no_wr_in_ack", bus.rf_wr_valid, 0);
    bus.dbg_req = 0;
    tick();
    #1;
    check("dw_ack_pulse", bus.dbg_ack, 0);
    bus.dbg_req = 1; bus.dbg_wr1_rd0 = 1; bus.dbg_regno = 0; bus.dbg_wdata = 32'hFFFF;
    tick();
    #1;
    check("dw0_no_wr", bus.rf_wr_valid, 0);
    tick();
    #1;
    check("dw0_ack", bus.dbg_ack, 1);
    check("dw0_no_wr_ack", bus.rf_wr_valid, 0);
    bus.dbg_req = 0;
    tick();

    // Debug read waits on the scoreboard
    bus.iss_valid = 1; bus.iss_rd = 4;
    tick();
    clr();
    bus.dbg_req = 1; bus.dbg_wr1_rd0 = 0; bus.dbg_regno = 4;
    tick();
    #1;
    check("dr_ridx", bus.rf_dbg_ridx, 4);
    check("dr_wait1", bus.dbg_ack, 0);
    tick();
    #1;
    check("dr_wait2", bus.dbg_ack, 0);
    bus.mdu_valid = 1; bus.mdu_rd = 4; bus.mdu_data = 32'h55;
    tick();
    bus.mdu_valid = 0;
    #1;
    check("dr_mdu_wr_rd", bus.rf_wr_rd, 4);
    check("dr_wait_hold", bus.dbg_ack, 0);
    tick();
    #1;
    check("dr_wait_capture", bus.dbg_ack, 0);
    tick();
    #1;
    check("dr_ack", bus.dbg_ack, 1);
    check("dr_rdata", bus.dbg_rdata, 32'h55);
    bus.dbg_req = 0;
    tick();
    #1;
    check("dr_ack_pulse", bus.dbg_ack, 0);
    check("dr_rdata_hold", bus.dbg_rdata, 32'h55);

    // Same-cycle set and clear of busy[4]: set wins
    bus.iss_valid = 1; bus.iss_rd = 4;
    tick();
    clr();
    bus.mdu_valid = 1; bus.mdu_rd = 4; bus.mdu_data = 32'h77;
    tick();
    clr();
    bus.iss_valid = 1; bus.iss_rd = 4;
    #1;
    check("sc_grant_rd", bus.rf_wr_rd, 4);
    tick();
    clr();
    #1;
    check("sc_busy4_kept", bus.busy[4], 1);

    // Reset mid-operation
    bus.iss_valid = 1; bus.iss_rd = 5;
    tick();
    clr();
    bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h1;
    bus.mdu_valid = 1; bus.mdu_rd = 8; bus.mdu_data = 32'h88;
    tick();
    bus.mdu_valid = 0;
    bus.dbg_req = 1; bus.dbg_wr1_rd0 = 0; bus.dbg_regno = 5;
    tick();
    #1;
    check("mr_pre_mdu_ready", bus.mdu_ready, 0);
    check("mr_pre_busy5", bus.busy[5], 1);
    check("mr_pre_ridx", bus.rf_dbg_ridx, 5);
    clr();
    #1;
    rstn = 1'b0;
    #1;
    check("mr_busy", bus.busy, 0);
    check("mr_mdu_ready", bus.mdu_ready, 1);
    check("mr_dbg_ack", bus.dbg_ack, 0);
    check("mr_wr_valid", bus.rf_wr_valid, 0);
    check("mr_ridx", bus.rf_dbg_ridx, 0);
    tick();
    rstn = 1'b1;
    tick();
    #1;
    check("mr_post_wr_valid", bus.rf_wr_valid, 0);
    check("mr_post_ack", bus.dbg_ack, 0);
    tick();
    #1;
    check("mr_post_wr_valid2", bus.rf_wr_valid, 0);
    check("mr_post_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
